btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Upstream stage for the blink/counter logic. Turns raw, bouncing, active-low board buttons BTN[N_BTN-1:0] into clean active-high levels plus single-cycle press, release and long-press events, all in the PCLK domain.
- Downstream, btn_level[0] replaces the raw ~BTN[0] counter reset, and the event outputs drive mode/step control.
- Runs on the undivided 8 MHz PCLK. Results cross to the CLK_DIV16 domain only as slow levels (btn_level, btn_long).

Parameters:
- N_BTN, 2, number of button channels.
- DEBOUNCE_CYC, 40000, stable PCLK cycles needed to accept a change (5 ms at 8 MHz). Must be >= 2.
- LONG_CYC, 8000000, PCLK cycles held in PRESSED before the long flag sets (1 s). Must be > DEBOUNCE_CYC.
- DCNT_W, $clog2(DEBOUNCE_CYC), debounce counter width.
- LCNT_W, $clog2(LONG_CYC), hold counter width.

Ports:
- PCLK  in  1  board clock, 8 MHz.
- reset  in  1  synchronous, active-high. Comes from a power-on/global source, never from this block's outputs.
- btn_n  in  N_BTN  raw buttons, active-low, asynchronous.
- btn_level  out  N_BTN  debounced state, 1 = pressed.
- btn_press  out  N_BTN  1-cycle pulse on accepted press.
- btn_release  out  N_BTN  1-cycle pulse on accepted release.
- btn_long  out  N_BTN  level: held >= LONG_CYC. Cleared on accepted release.

Behaviour:
- Channels are independent and identical. Everything below is per channel.
- Synchroniser:
  - 2-FF chain on btn_n; reset value 1 (released).
  - raw_s = ~(second FF output).
  - No other logic samples btn_n.
- FSM states, 2-bit encoding:
  - IDLE=0, WAIT_P=1, PRESSED=2, WAIT_R=3.
  - Next state and outputs are all registered.
- IDLE:
  - If raw_s=1: go to WAIT_P, dcnt<=0.
- WAIT_P:
  - If raw_s=0: go to IDLE (bounce rejected, no pulse).
  - Else if dcnt==DEBOUNCE_CYC-1: go to PRESSED, btn_press<=1 for one cycle, btn_level<=1, hcnt<=0.
  - Else dcnt<=dcnt+1.
- PRESSED:
  - hcnt increments while raw_s=1 and saturates at LONG_CYC-1.
  - The cycle hcnt reaches LONG_CYC-1, btn_long<=1. It stays set.
  - If raw_s=0: go to WAIT_R, dcnt<=0.
- WAIT_R:
  - If raw_s=1: go back to PRESSED (bounce rejected). hcnt holds its value, no pulse.
  - Else if dcnt==DEBOUNCE_CYC-1: go to IDLE, btn_release<=1 for one cycle, btn_level<=0, btn_long<=0.
  - Else dcnt<=dcnt+1.
- hcnt is frozen in WAIT_R and cleared only on WAIT_P->PRESSED.
- Latency:
  - A clean press stable from the first PCLK edge that samples btn_n=0 gives btn_press high in the register output after DEBOUNCE_CYC+3 edges.
  - Release latency is identical.
  - btn_level changes in the same cycle as the corresponding pulse.
- btn_press and btn_release are never both high on one channel in one cycle. Each pulse is exactly 1 cycle wide.
- Counters never wrap: dcnt is bounded by its compare; hcnt saturates.
- Reset, including mid-debounce or mid-hold:
  - State goes to IDLE; dcnt and hcnt go to 0; sync FFs go to 1.
  - All outputs go to 0 in the cycle after the reset edge.
  - A button held through reset is detected as a fresh press: DEBOUNCE_CYC+3 cycles after reset deasserts, then a btn_press pulse.
- Simultaneous events on different channels are fully independent. No priority between channels.

Decomposition:
- Shared package/include btn_pkg:
  - state localparams ST_IDLE, ST_WAIT_P, ST_PRESSED, ST_WAIT_R.
  - default timing constants DEBOUNCE_5MS_8MHZ=40000 and LONG_1S_8MHZ=8000000.
- Sub-module btn_debounce_ch: one channel covering sync, FSM and both counters. Same parameters minus N_BTN.
- btn_conditioner instantiates btn_debounce_ch N_BTN times via generate and concatenates the outputs.

Test Plan (bench parameters DEBOUNCE_CYC=4, LONG_CYC=16, N_BTN=2):
- Reset asserted 3 cycles with btn_n=2'b11 -> all outputs 0. Release with no activity -> outputs stay 0 for 50 cycles.
- btn_n[0] low and held -> btn_press[0] 1-cycle pulse and btn_level[0]=1 exactly 7 edges after the first low sample. Channel 1 stays quiet.
- btn_n[0] bounce pattern 0,1,0,0,1 (1-cycle each), then stable high -> no btn_press[0], btn_level[0] stays 0.
- Hold btn_n[1] low for 40 cycles, then release -> btn_long[1] rises 16 cycles after btn_press[1]. btn_release[1] pulses 7 edges after the release. btn_long[1] clears in the same cycle as that pulse.
- While PRESSED, inject a 2-cycle high glitch on btn_n[0] -> no btn_release[0], btn_level[0] stays 1, hcnt resumes and btn_long timing is shifted by the glitch length only.
- Reset asserted while channel 0 is in WAIT_P with btn_n[0] still low -> outputs 0. After reset deasserts, btn_press[0] pulses 7 edges later.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM states and
// default timing constants for the 8 MHz board clock.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_P  = 2'd1,
    ST_PRESSED = 2'd2,
    ST_WAIT_R  = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_5MS_8MHZ = 40000;
  localparam int LONG_1S_8MHZ      = 8000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM with press/release
// pulses, and a saturating hold counter for the long-press level.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_5MS_8MHZ,
  parameter int LONG_CYC     = LONG_1S_8MHZ,
  parameter int DCNT_W       = $clog2(DEBOUNCE_CYC),
  parameter int LCNT_W       = $clog2(LONG_CYC)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [LCNT_W-1:0] HCNT_LAST = LCNT_W'(LONG_CYC - 1);

  logic [1:0]        sync_q;
  logic              raw_s;
  btn_state_e        state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [LCNT_W-1:0] hcnt_q, hcnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Synchroniser resets to "released" so a held button reads as a fresh press.
  assign raw_s = ~sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_n_i};
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = long_q;
    unique case (state_q)
      ST_IDLE: begin
        if (raw_s) begin
          state_d = ST_WAIT_P;
          dcnt_d  = '0;
        end
      end
      ST_WAIT_P: begin
        if (!raw_s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!raw_s) begin
          state_d = ST_WAIT_R;
          dcnt_d  = '0;
        end else if (hcnt_q == HCNT_LAST) begin
          // Saturated: one more held cycle makes LONG_CYC in total.
          long_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + LCNT_W'(1);
        end
      end
      ST_WAIT_R: begin
        if (raw_s) begin
          state_d = ST_PRESSED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          long_d    = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces N_BTN raw active-low buttons into clean levels plus press,
// release and long-press events; channels are fully independent.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_5MS_8MHZ,
  parameter int LONG_CYC     = LONG_1S_8MHZ,
  parameter int DCNT_W       = $clog2(DEBOUNCE_CYC),
  parameter int LCNT_W       = $clog2(LONG_CYC)
) (
  input  logic             PCLK,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .DCNT_W      (DCNT_W),
      .LCNT_W      (LCNT_W)
    ) u_ch (
      .clk_i    (PCLK),
      .rst_i    (reset),
      .btn_n_i  (btn_n[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i])
    );
  end

endmodule
